adder_bist: RTL
===============

Name: adder_bist

Overview:
- Synthesizable, parametrised self-checking harness for any N-bit adder DUV (cra, csa, cla, a1csa, ...).
- Successor to the per-width file-driven benches. Generates directed plus pseudo-random vectors, drives a/b/cin, and computes the reference sum internally.
- Aligns the result to a configurable DUV pipeline latency, compares sum/carry, and reports pass/fail, error count and first failing vector.
- Sits beside the DUV in gate-level and switching-activity runs, so no file I/O is needed.

Parameters:
- N, 16, operand width; legal range 4..31.
- NUM_VECTORS, 30000, total vectors applied, including the 4 directed ones; legal range ≥4.
- DUV_LAT, 0, DUV latency in clk cycles; 0 means combinational; legal range 0..8.
- SEED, 64'h0123_4567_89AB_CDEF, xorshift64 seed; must be nonzero.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse that starts a run; accepted in IDLE or DONE.
- a, out, N, operand A to DUV.
- b, out, N, operand B to DUV.
- cin, out, 1, carry-in to DUV.
- s_duv, in, N, DUV sum.
- cout_duv, in, 1, DUV carry-out.
- busy, out, 1, high in RUN and DRAIN.
- done, out, 1, high in DONE; held until start or reset.
- pass, out, 1, valid when done=1; 1 iff err_count==0.
- err_count, out, 16, mismatching vectors; saturates at 16'hFFFF.
- vec_count, out, 32, vectors applied so far.
- first_fail_idx, out, 32, index of first mismatching vector; 32'hFFFF_FFFF if none.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; a=b=0; cin=0; busy=done=pass=0; err_count=0; vec_count=0; first_fail_idx=32'hFFFF_FFFF; LFSR=SEED; expected pipeline cleared with its valid bits 0.
- Reset mid-run aborts immediately; no done pulse is produced.
- IDLE: outputs hold. start=1 → RUN next edge. On entry to RUN: counters cleared, LFSR=SEED, first_fail_idx=all ones.
- RUN: one vector per cycle, registered on a/b/cin.
  - Vector index 0: a=0, b=0, cin=0.
  - Index 1: a=all ones, b=0, cin=1 (full ripple).
  - Index 2: a=all ones, b=all ones, cin=1.
  - Index 3: a=0101..., b=1010..., cin=1.
  - Index ≥4: one xorshift64 step (x^=x<<13; x^=x>>7; x^=x<<17); a=x[N-1:0], b=x[2N-1:N], cin=x[63].
  - vec_count increments per vector applied.
  - After vector NUM_VECTORS-1 is applied → DRAIN.
- Expected value {cout,s} = a+b+cin, computed in N+1 bits with no truncation. It enters a delay line of DUV_LAT stages tagged with a valid bit and vector index.
- Compare: at the first edge where a vector has been on a/b/cin for DUV_LAT+1 edges, sample s_duv/cout_duv and compare with the delayed expected value (DUV_LAT=0: same cycle, combinational path).
  - A mismatch on either sum or carry counts as one error.
  - err_count increments, saturating at 16'hFFFF.
  - first_fail_idx is latched only while it equals all ones.
- DRAIN: a/b/cin hold the last vector. Lasts until every valid pipeline entry is compared, i.e. DUV_LAT+1 cycles. Then → DONE.
- DONE: done=1, busy=0, pass=(err_count==0). start → RUN, which fully restarts.
- start during RUN/DRAIN is ignored. start coincident with rst_n=0: reset wins.
- vec_count counts only to NUM_VECTORS; no wrap.

Optional Feature:
- Macro ADDER_BIST_PG_CHECK_EN.
- Defined:
  - Extra inputs prop_duv and gen_duv (1 bit each) for cla/a1csah DUVs.
  - Reference values: prop = &(a^b); gen = carry-out of a+b with cin=0. Both are delayed through the same pipeline.
  - Any mismatch of s, cout, prop or gen counts as one error.
- Undefined: the ports are absent and only s/cout are checked.

Test Plan:
- N=16, DUV_LAT=0, ideal combinational adder, start pulse → vector 1 shows a=16'hFFFF, b=0, cin=1 with s=0, cout=1. done asserts after 30000+1 RUN/DRAIN cycles with pass=1, err_count=0, first_fail_idx=32'hFFFFFFFF.
- DUV with sum bit 5 stuck at 0, NUM_VECTORS=8 → vector 2 (FFFF+FFFF+1=1FFFF, bit5=1) fails, so first_fail_idx=2 and err_count≥1 at done.
- DUV_LAT=3 with a 3-stage registered adder → pass=1; busy high exactly NUM_VECTORS+4 cycles.
- rst_n low for 1 cycle at vector 100 → all outputs at reset values; a new start runs cleanly with the identical vector sequence (same SEED).
- Adder forced to always output 0, NUM_VECTORS=70000 → err_count saturates at 16'hFFFF, first_fail_idx=1 (vector 0 passes), pass=0.
- ADDER_BIST_PG_CHECK_EN defined, N=8: vector a=8'h55, b=8'hAA → expected prop=1, gen=0; a DUV reporting gen=1 → err_count=1.

Source files
------------

// File: rtl/adder_bist.sv
// adder_bist: self-checking stimulus/compare harness for an N-bit adder DUV.
// Define ADDER_BIST_PG_CHECK_EN to add prop_duv/gen_duv inputs and check them too.
module adder_bist #(
  parameter int N = 16,
  parameter int NUM_VECTORS = 30000,
  parameter int DUV_LAT = 0,
  parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic          cin,
  input  logic [N-1:0]  s_duv,
  input  logic          cout_duv,
`ifdef ADDER_BIST_PG_CHECK_EN
  input  logic          prop_duv,
  input  logic          gen_duv,
`endif
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [31:0]   vec_count,
  output logic [31:0]   first_fail_idx
);
  // Expected entry: {valid, vector index, gen, prop, cout, sum}
  localparam int EW = N + 3;
  localparam int PW = EW + 33;
  localparam logic [N-1:0] ALT = N'({N{2'b01}});
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t        r_state;
  logic [63:0]   r_x;
  logic          r_v;
  logic [3:0]    r_dc;
  logic [63:0]   w_x1, w_x2, w_x3;
  logic [N:0]    w_ab, w_sum;
  logic [N-1:0]  w_va, w_vb;
  logic          w_vc, w_mis;
  logic [PW-1:0] w_e0, w_t;
  logic [EW-1:0] w_act;
  assign w_x1 = r_x ^ (r_x << 13);
  assign w_x2 = w_x1 ^ (w_x1 >> 7);
  assign w_x3 = w_x2 ^ (w_x2 << 17);
  assign w_va = vec_count == 32'd0 ? '0 : vec_count < 32'd3 ? '1 :
                vec_count == 32'd3 ? ALT : w_x3[N-1:0];
  assign w_vb = vec_count < 32'd2 ? '0 : vec_count == 32'd2 ? '1 :
                vec_count == 32'd3 ? ~ALT : w_x3[2*N-1:N];
  assign w_vc = vec_count == 32'd0 ? 1'b0 : vec_count < 32'd4 ? 1'b1 : w_x3[63];
  assign w_ab = {1'b0, a} + {1'b0, b};
  assign w_sum = w_ab + {{N{1'b0}}, cin};
  assign w_e0 = {r_v, vec_count - 32'd1, w_ab[N], &(a ^ b), w_sum};
  generate
    if (DUV_LAT == 0) begin : g_comb
      assign w_t = w_e0;
    end else begin : g_pipe
      logic [PW-1:0] r_p [DUV_LAT];
      always_ff @(posedge clk) begin
        r_p[0] <= rst_n ? w_e0 : '0;
        for (int i = 1; i < DUV_LAT; i++) r_p[i] <= rst_n ? r_p[i-1] : '0;
      end
      assign w_t = r_p[DUV_LAT-1];
    end
  endgenerate
`ifdef ADDER_BIST_PG_CHECK_EN
  assign w_act = {gen_duv, prop_duv, cout_duv, s_duv};
`else
  assign w_act = {w_t[N+2:N+1], cout_duv, s_duv};
`endif
  assign w_mis = w_t[PW-1] && (w_act != w_t[EW-1:0]);
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
  assign pass = done && err_count == 16'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      a <= '0;
      b <= '0;
      cin <= 1'b0;
      r_x <= SEED;
      r_v <= 1'b0;
      r_dc <= '0;
      err_count <= '0;
      vec_count <= '0;
      first_fail_idx <= '1;
    end else begin
      r_v <= r_state == RUN;
      if (w_mis && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (w_mis && first_fail_idx == '1) first_fail_idx <= w_t[PW-2:EW];
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= RUN;
          r_x <= SEED;
          err_count <= '0;
          vec_count <= '0;
          first_fail_idx <= '1;
        end
        RUN: begin
          a <= w_va;
          b <= w_vb;
          cin <= w_vc;
          if (vec_count >= 32'd4) r_x <= w_x3;
          vec_count <= vec_count + 32'd1;
          if (vec_count == 32'(NUM_VECTORS - 1)) begin
            r_state <= DRAIN;
            r_dc <= '0;
          end
        end
        DRAIN: begin
          if (r_dc == 4'(DUV_LAT)) r_state <= DONE;
          else r_dc <= r_dc + 4'd1;
        end
      endcase
    end
  end
endmodule
